// File: rtl/loxodes_pgood_monitor.sv
// loxodes_pgood_monitor: power-good supervisor downstream of the channel
// power sequencer. Drives the sequencer enable, checks every enabled channel
// reaches and holds power-good, and latches the first fault cause/channel.
module loxodes_pgood_monitor #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned TW          = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            clear_fault,
    input  logic [TW-1:0]   timeout,
    input  logic [N_CH-1:0] chan_en,
    input  logic [N_CH-1:0] pgood_in,
    output logic            seq_enable,
    output logic            all_good,
    output logic            fault,
    output logic [2:0]      fault_chan,
    output logic [1:0]      fault_code
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_TIMEOUT = 2'b01,
        FC_DROPOUT = 2'b10,
        FC_EN_DROP = 2'b11
    } fcode_t;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [N_CH-1:0] pgood_s;

    logic [TW-1:0]   timer_q [N_CH];
    logic [TW-1:0]   timer_d [N_CH];
    logic [N_CH-1:0] good_seen_q, good_seen_d;
    logic [N_CH-1:0] chan_en_prev_q, chan_en_prev_d;

    state_t          state_q, state_d;
    logic            seq_enable_q, seq_enable_d;
    logic            all_good_q, all_good_d;
    logic            fault_q, fault_d;
    logic [2:0]      fault_chan_q, fault_chan_d;
    fcode_t          fault_code_q, fault_code_d;

    logic            det_fault;
    logic [2:0]      det_chan;
    fcode_t          det_code;

    // Synchroniser chain for the asynchronous power-good inputs
    always_comb begin
        sync_d[0] = pgood_in;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign pgood_s        = sync_q[SYNC_STAGES-1];
    assign chan_en_prev_d = chan_en;

    // Per-channel timers/good_seen flags and lowest-index fault detection
    always_comb begin
        good_seen_d = good_seen_q;
        det_fault   = 1'b0;
        det_chan    = '0;
        det_code    = FC_NONE;
        for (int unsigned i = 0; i < N_CH; i++) begin
            timer_d[i] = timer_q[i];
            if (!chan_en[i]) begin
                timer_d[i]     = '0;
                good_seen_d[i] = 1'b0;
            end else if (pgood_s[i]) begin
                good_seen_d[i] = 1'b1;
            end else if (!good_seen_q[i] && (timer_q[i] != '1)) begin
                timer_d[i] = timer_q[i] + 1'b1;
            end

            // Causes on one channel are mutually exclusive; order gives the
            // timeout > dropout > enable-drop ranking anyway.
            if (!det_fault) begin
                if (chan_en[i] && !good_seen_q[i] && !pgood_s[i] && (timer_q[i] == timeout)) begin
                    det_fault = 1'b1;
                    det_chan  = 3'(i);
                    det_code  = FC_TIMEOUT;
                end else if (chan_en[i] && good_seen_q[i] && !pgood_s[i]) begin
                    det_fault = 1'b1;
                    det_chan  = 3'(i);
                    det_code  = FC_DROPOUT;
                end else if (chan_en_prev_q[i] && !chan_en[i]) begin
                    det_fault = 1'b1;
                    det_chan  = 3'(i);
                    det_code  = FC_EN_DROP;
                end
            end
        end
    end

    // Supervisor state transitions and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (start && !stop && (chan_en == '0)) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (det_fault)                   state_d = ST_FAULT;
                else if (stop)                   state_d = ST_RAMP_DOWN;
                else if ((&chan_en) && (&pgood_s)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (det_fault)  state_d = ST_FAULT;
                else if (stop)  state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (chan_en == '0) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (clear_fault && (chan_en == '0)) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        seq_enable_d = (state_d == ST_RAMP_UP) || (state_d == ST_RUN);
        all_good_d   = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);

        fault_chan_d = fault_chan_q;
        fault_code_d = fault_code_q;
        if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
            fault_chan_d = det_chan;
            fault_code_d = det_code;
        end else if (state_d != ST_FAULT) begin
            fault_chan_d = '0;
            fault_code_d = FC_NONE;
        end
    end

    // All state and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int unsigned i = 0; i < N_CH; i++) timer_q[i] <= '0;
            good_seen_q    <= '0;
            chan_en_prev_q <= '0;
            state_q        <= ST_OFF;
            seq_enable_q   <= 1'b0;
            all_good_q     <= 1'b0;
            fault_q        <= 1'b0;
            fault_chan_q   <= '0;
            fault_code_q   <= FC_NONE;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
            for (int unsigned i = 0; i < N_CH; i++) timer_q[i] <= timer_d[i];
            good_seen_q    <= good_seen_d;
            chan_en_prev_q <= chan_en_prev_d;
            state_q        <= state_d;
            seq_enable_q   <= seq_enable_d;
            all_good_q     <= all_good_d;
            fault_q        <= fault_d;
            fault_chan_q   <= fault_chan_d;
            fault_code_q   <= fault_code_d;
        end
    end

    assign seq_enable = seq_enable_q;
    assign all_good   = all_good_q;
    assign fault      = fault_q;
    assign fault_chan = fault_chan_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_loxodes_pgood_monitor.sv
// Directed bench for loxodes_pgood_monitor. The bench plays the sequencer
// (one channel per cycle up while seq_enable=1, down otherwise) and the
// regulators (pgood rises 3 cycles after a channel is enabled, with a
// per-channel kill mask to model failures).
module tb_loxodes_pgood_monitor;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clear_fault;
    logic [4:0] timeout;
    logic [7:0] chan_en;
    logic [7:0] pgood_in;
    logic       seq_enable;
    logic       all_good;
    logic       fault;
    logic [2:0] fault_chan;
    logic [1:0] fault_code;

    logic [7:0] model_pg;
    logic [7:0] kill;
    logic       seq_auto;
    int         age [8];

    int checks = 0;
    int errors = 0;

    loxodes_pgood_monitor #(
        .N_CH        (8),
        .TW          (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear_fault (clear_fault),
        .timeout     (timeout),
        .chan_en     (chan_en),
        .pgood_in    (pgood_in),
        .seq_enable  (seq_enable),
        .all_good    (all_good),
        .fault       (fault),
        .fault_chan  (fault_chan),
        .fault_code  (fault_code)
    );

    assign pgood_in = model_pg & ~kill;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; then the sequencer and regulator models react to the new outputs
    task automatic step();
        @(posedge clk);
        #1;
        if (seq_auto) begin
            if (seq_enable) chan_en = {chan_en[6:0], 1'b1};
            else            chan_en = {1'b0, chan_en[7:1]};
        end
        for (int i = 0; i < 8; i++) begin
            if (!chan_en[i])    age[i] = 0;
            else if (age[i] < 7) age[i] = age[i] + 1;
            model_pg[i] = (age[i] >= 3);
        end
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear_fault = 1'b0;
        kill        = 8'h00;
        seq_auto    = 1'b1;
        chan_en     = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic power_up(output int n_out);
        int n = 0;
        start = 1'b1;
        while (!all_good && n < 40) begin
            step();
            n++;
        end
        start = 1'b0;
        n_out = n;
        check_eq("pwrup_all_good", all_good, 1);
        check_eq("pwrup_fault", fault, 0);
        check_eq("pwrup_seq_en", seq_enable, 1);
    endtask

    task automatic wait_fault(input int max_n, output int n_out);
        int n = 0;
        while (!fault && n < max_n) begin
            step();
            n++;
        end
        n_out = n;
    endtask

    task automatic drain_and_clear(input string tag);
        int n = 0;
        seq_auto = 1'b1;
        while (chan_en != 8'h00 && n < 12) begin
            step();
            n++;
        end
        check_eq({tag, "_held"}, fault, 1);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check_eq({tag, "_clr_fault"}, fault, 0);
        check_eq({tag, "_clr_code"}, fault_code, 0);
        check_eq({tag, "_clr_chan"}, fault_chan, 0);
        check_eq({tag, "_clr_seq"}, seq_enable, 0);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear_fault = 1'b0;
        timeout     = 5'd10;
        chan_en     = 8'h00;
        kill        = 8'h00;
        model_pg    = 8'h00;
        seq_auto    = 1'b1;
        for (int i = 0; i < 8; i++) age[i] = 0;

        // Reset state
        reset_dut();
        check_eq("rst_seq_en", seq_enable, 0);
        check_eq("rst_all_good", all_good, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_chan", fault_chan, 0);
        check_eq("rst_code", fault_code, 0);

        // 1: normal power-up; last channel good_s at edge 13
        timeout = 5'd10;
        power_up(n);
        check_eq("t1_cycles", n, 13);

        // 2: timeout on channel 3 (first enabled edge 5, timeout 4 -> edge 9)
        reset_dut();
        timeout = 5'd4;
        kill    = 8'h08;
        start   = 1'b1;
        wait_fault(30, n);
        start = 1'b0;
        check_eq("t2_cycles", n, 9);
        check_eq("t2_fault", fault, 1);
        check_eq("t2_code", fault_code, 2'b01);
        check_eq("t2_chan", fault_chan, 3);
        check_eq("t2_seq_en", seq_enable, 0);
        check_eq("t2_all_good", all_good, 0);
        kill = 8'h00;
        drain_and_clear("t2");

        // 3a: 4-cycle dropout on channel 5 (2 sync stages + 1 detect)
        timeout = 5'd10;
        power_up(n);
        kill = 8'h20;
        n = 0;
        while (!fault && n < 8) begin
            step();
            n++;
            if (n == 4) kill = 8'h00;
        end
        kill = 8'h00;
        check_eq("t3a_cycles", n, 3);
        check_eq("t3a_code", fault_code, 2'b10);
        check_eq("t3a_chan", fault_chan, 5);
        check_eq("t3a_all_good", all_good, 0);
        drain_and_clear("t3a");

        // 3b: single-cycle low pulse straddling one sampling edge
        power_up(n);
        kill = 8'h20;
        n = 0;
        while (!fault && n < 8) begin
            step();
            n++;
            if (n == 1) kill = 8'h00;
        end
        kill = 8'h00;
        check_eq("t3b_cycles", n, 3);
        check_eq("t3b_code", fault_code, 2'b10);
        check_eq("t3b_chan", fault_chan, 5);
        drain_and_clear("t3b");

        // 4: simultaneous dropouts on 2 and 6 -> lowest index
        power_up(n);
        kill = 8'h44;
        wait_fault(8, n);
        kill = 8'h00;
        check_eq("t4_cycles", n, 3);
        check_eq("t4_code", fault_code, 2'b10);
        check_eq("t4_chan", fault_chan, 2);
        drain_and_clear("t4");

        // 4b: enable of channel 4 drops while running
        power_up(n);
        seq_auto = 1'b0;
        chan_en  = 8'hEF;
        step();
        check_eq("t4b_fault", fault, 1);
        check_eq("t4b_code", fault_code, 2'b11);
        check_eq("t4b_chan", fault_chan, 4);
        drain_and_clear("t4b");

        // 5: stop after three channels enabled
        reset_dut();
        timeout = 5'd10;
        start   = 1'b1;
        step();
        check_eq("t5_seq_up", seq_enable, 1);
        step();
        step();
        start = 1'b0;
        stop  = 1'b1;
        step();
        check_eq("t5_seq_down", seq_enable, 0);
        check_eq("t5_fault", fault, 0);
        n = 0;
        while (chan_en != 8'h00 && n < 12) begin
            step();
            n++;
        end
        step();
        stop     = 1'b0;
        seq_auto = 1'b0;
        chan_en  = 8'h01;
        start    = 1'b1;
        step();
        step();
        check_eq("t5_start_ignored", seq_enable, 0);
        chan_en = 8'h00;
        stop    = 1'b1;
        step();
        check_eq("t5_stop_wins", seq_enable, 0);
        stop = 1'b0;
        step();
        check_eq("t5_start_ok", seq_enable, 1);
        start = 1'b0;

        // 6a: reset in RUN
        reset_dut();
        power_up(n);
        reset = 1'b1;
        step();
        check_eq("t6_rst_seq", seq_enable, 0);
        check_eq("t6_rst_good", all_good, 0);
        check_eq("t6_rst_fault", fault, 0);
        check_eq("t6_rst_chan", fault_chan, 0);
        check_eq("t6_rst_code", fault_code, 0);
        reset_dut();

        // 6b: timeout=0 faults on first enabled cycle; clear ignored while enabled
        timeout  = 5'd0;
        seq_auto = 1'b0;
        start    = 1'b1;
        step();
        check_eq("t6_seq_up", seq_enable, 1);
        start   = 1'b0;
        chan_en = 8'h01;
        step();
        check_eq("t6_fault", fault, 1);
        check_eq("t6_code", fault_code, 2'b01);
        check_eq("t6_chan", fault_chan, 0);
        check_eq("t6_seq_off", seq_enable, 0);
        clear_fault = 1'b1;
        step();
        step();
        check_eq("t6_clr_ignored", fault, 1);
        check_eq("t6_code_held", fault_code, 2'b01);
        clear_fault = 1'b0;
        chan_en     = 8'h00;
        step();
        check_eq("t6_need_reassert", fault, 1);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check_eq("t6_cleared", fault, 0);
        check_eq("t6_cleared_code", fault_code, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loxodes_pgood_monitor.md
Name: loxodes_pgood_monitor

Overview:
Supervisor that sits directly downstream of the channel power sequencer. It consumes the sequencer's 8 channel enables plus 8 external power-good inputs, and drives the sequencer's enable line. It accepts on/off requests, verifies that every enabled channel reaches power-good within a programmable timeout and stays good, and on any violation forces a sequenced shutdown. Fault cause and channel are latched for readout.

Parameters:
N_CH, 8, number of channels (fault_chan width fixed at 3 bits for N_CH=8)
TW, 5, width of timeout input and per-channel timers
SYNC_STAGES, 2, flop stages on pgood_in before use

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  power-on request, level-sampled
stop  input  1  power-off request, level-sampled; wins over start
clear_fault  input  1  acknowledge and clear a latched fault
timeout  input  TW  max wait cycles for pgood after enable
chan_en  input  N_CH  channel enables from sequencer
pgood_in  input  N_CH  asynchronous power-good from regulators
seq_enable  output  1  enable to sequencer (1 = ramp up, 0 = ramp down)
all_good  output  1  high only in RUN
fault  output  1  latched fault flag
fault_chan  output  3  index of faulting channel
fault_code  output  2  00 none, 01 timeout, 10 dropout, 11 unexpected enable drop

Behaviour:
- Reset: state OFF. seq_enable=0, all_good=0, fault=0, fault_chan=0, fault_code=00. Timers, good_seen flags and sync flops all cleared.
- pgood_s = pgood_in after SYNC_STAGES flops (2-cycle latency).
- Per channel i:
  - timer[i] clears when chan_en[i]=0. Otherwise it increments while chan_en[i]=1, good_seen[i]=0 and pgood_s[i]=0, saturating at all-ones.
  - good_seen[i] sets when chan_en[i]=1 and pgood_s[i]=1. It clears when chan_en[i]=0.
- Fault detection is evaluated only in RAMP_UP and RUN:
  - timeout: chan_en[i]=1, good_seen[i]=0, pgood_s[i]=0 and timer[i]==timeout. This means timeout+1 unsatisfied enabled cycles; timeout=0 faults on the first such cycle.
  - dropout: good_seen[i]=1, chan_en[i]=1, pgood_s[i]=0.
  - unexpected drop: chan_en[i] falls 1->0 while in RAMP_UP or RUN.
  - Simultaneous faults: the lowest channel index wins. On one channel, timeout > dropout > enable drop.
- States:
  - OFF: seq_enable=0. Goes to RAMP_UP when start=1, stop=0 and chan_en==0. A start request with chan_en!=0 is ignored (still draining).
  - RAMP_UP: seq_enable=1.
    - Goes to RUN when chan_en all ones and pgood_s all ones.
    - Goes to RAMP_DOWN on stop.
    - Goes to FAULT on a detected fault.
  - RUN: seq_enable=1, all_good=1. Goes to RAMP_DOWN on stop. Goes to FAULT on a detected fault (fault has priority over stop in the same cycle).
  - RAMP_DOWN: seq_enable=0. Faults are ignored. Goes to OFF when chan_en==0.
  - FAULT: seq_enable=0. fault=1, and fault_chan/fault_code are written on the entry cycle and held.
    - Goes to OFF when clear_fault=1 and chan_en==0.
    - clear_fault while chan_en!=0 is ignored; it must be reasserted.
    - start and stop are ignored.
- Outputs are registered. fault/all_good/seq_enable change one cycle after the triggering condition. On FAULT->OFF, fault, fault_chan and fault_code return to 0.
- Reset mid-operation: immediate return to reset values. seq_enable=0 makes the sequencer ramp down on its own.

Test Plan:
1. Power-up: timeout=10. Drive start=1, with a model that raises pgood_in[i] 3 cycles after chan_en[i] rises -> reaches RUN, all_good=1, fault stays 0.
2. Timeout: timeout=4. pgood_in[3] is never asserted -> FAULT, fault_code=01, fault_chan=3, seq_enable=0 the next cycle. After chan_en reaches 0, clear_fault=1 -> OFF with fault=0.
3. Dropout: in RUN, pulse pgood_in[5] low for 4 cycles -> fault_code=10, fault_chan=5. A 1-cycle pulse shorter than the sync window is still caught if sampled; verify both cases deterministically.
4. Simultaneous: in RUN, drop pgood_in[2] and pgood_in[6] on the same cycle -> fault_chan=2.
5. Stop during ramp: stop=1 after 3 channels are enabled -> RAMP_DOWN, then OFF when chan_en==0. A start asserted while chan_en!=0 is ignored.
6. Reset mid-RUN -> next cycle all outputs are 0 and state is OFF. Then clear_fault while chan_en=8'h01 in FAULT has no effect.
